// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared UART frame width, default oversampling, FSM states |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W                = 8;
  localparam int DEFAULT_SAMPLING_RATE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge: 2-flop synchronizer plus rising-edge detector            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  // stage[1] is the synchronized level, stage[2] its one-cycle-old copy
  logic [2:0] stage;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= {3{RESET_VAL}};
    end else begin
      stage <= {stage[1:0], din};
    end
  end

  assign rise = stage[1] & ~stage[2];

endmodule : sync_edge
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_sampler: 8N1 UART receiver oversampled by a synchronized    |
// | baud tick, all logic in the clk domain.  Rev 1.0                    |
// +--------------------------------------------------------------------+
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SAMPLING_RATE = DEFAULT_SAMPLING_RATE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud,
  input  logic              bit_in,
  output logic [DATA_W-1:0] data_received,
  output logic              received,
  output logic              receiving,
  output logic              framing_error
);

  localparam int                CNT_W     = $clog2(SAMPLING_RATE);
  localparam int                IDX_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(SAMPLING_RATE / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(SAMPLING_RATE - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);

  logic              tick;
  logic [1:0]        rx_sync;
  logic              rx_s;

  uart_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  bit_idx, bit_idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DATA_W-1:0] data_n;
  logic              received_n, framing_error_n;

  sync_edge #(
    .RESET_VAL (1'b0)
  ) u_baud_sync (
    .clk   (clk),
    .reset (reset),
    .din   (baud),
    .rise  (tick)
  );

  // RX line resets to the idle (mark) level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], bit_in};
    end
  end

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      sh            <= '0;
      data_received <= '0;
      received      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      sh            <= sh_n;
      data_received <= data_n;
      received      <= received_n;
      framing_error <= framing_error_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    bit_idx_n       = bit_idx;
    sh_n            = sh;
    data_n          = data_received;
    received_n      = 1'b0;
    framing_error_n = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n = '0;
            // A line back high at mid start bit was only a glitch
            if (!rx_s) begin
              state_n   = DATA;
              bit_idx_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_n = '0;
            sh_n  = {rx_s, sh[DATA_W-1:1]};
            if (bit_idx == LAST_IDX) begin
              state_n = STOP;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              data_n     = sh;
              received_n = 1'b1;
              state_n    = IDLE;
            end else begin
              framing_error_n = 1'b1;
              state_n         = BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait for the line to return to mark so a held-low line cannot retrigger
          if (rx_s) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign receiving = (state == START) || (state == DATA) || (state == STOP);

endmodule : uart_rx_sampler
`default_nettype wire

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Single-clock UART receiver, the receive-side counterpart of the transmit wrapper: recovers 8N1 frames from the PMOD/USB RX pin using the shared oversampling `baud` square wave. Unlike the transmitter, `baud` is never used as a clock here. It is synchronized and edge-detected into a one-`clk` tick, so the whole block runs in the `clk` domain. It delivers the received byte plus a one-cycle `received` pulse to the system-side FSMs.

## Interface
- `SAMPLING_RATE`, 16: `baud` rising edges per bit period; even, ≥4.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `baud`  in  1  oversampling square wave from the baud generator; asynchronous to `clk`, at most `clk`/4.
- `bit_in`  in  1  raw RX line; asynchronous; idle high.
- `data_received`  out  8  last good byte, LSB first on the line.
- `received`  out  1  one-`clk` pulse when `data_received` updates.
- `receiving`  out  1  high while a frame is in progress.
- `framing_error`  out  1  one-`clk` pulse when the stop bit is sampled low.

## Operation
- `baud` passes through 3 flops (b1, b2, b3); `tick = b2 & ~b3`. Exactly one `clk`-wide tick per `baud` rising edge.
- `bit_in` passes through 2 flops into `rx_s`, which resets to 1. All FSM decisions use `rx_s`, and only on tick cycles.
- `cnt` is `$clog2(SAMPLING_RATE)` bits wide. `bit_idx` is 3 bits. The shift register `sh` is 8 bits.
- FSM states:
  - IDLE: on a tick with `rx_s==0`: go to START, `cnt<=0`.
  - START: on a tick, `cnt++`. At `cnt==SAMPLING_RATE/2-1` (mid start bit):
    - if `rx_s==0`: go to DATA, `cnt<=0`, `bit_idx<=0`;
    - otherwise it was a glitch: go to IDLE with no outputs.
  - DATA: on a tick, `cnt++`. At `cnt==SAMPLING_RATE-1`:
    - `sh <= {rx_s, sh[7:1]}`, `cnt<=0`;
    - if `bit_idx==7`, go to STOP; otherwise `bit_idx++`.
  - STOP: on a tick at `cnt==SAMPLING_RATE-1`:
    - if `rx_s==1`: `data_received<=sh`, pulse `received`, go to IDLE;
    - otherwise: pulse `framing_error`, leave `data_received` unchanged, go to BREAK.
  - BREAK: on a tick with `rx_s==1`: go to IDLE. A held-low line therefore never retriggers a frame.
- `receiving` is 1 in START, DATA and STOP, and 0 in IDLE and BREAK.
- Reset values: state IDLE; `cnt`, `bit_idx`, `sh` and `data_received` = 0; `received`, `framing_error` and `receiving` = 0; sync flops = 0 for `baud` and 1 for `rx_s`.
- Reset mid-frame aborts the frame immediately. No `received` or `framing_error` pulse is produced for the aborted frame.

## Timing
- Tick latency: a `baud` rising edge captured at posedge N produces a tick in cycle N+2.
- `received` and `framing_error` are registered. They are high for exactly the cycle after the tick that samples the stop bit.
- `data_received` becomes valid in the same cycle as `received` and holds until the next good frame.
- Sampling points are taken at SAMPLING_RATE/2 ticks after start detection, then every SAMPLING_RATE ticks (bit centres).
- Frame length from start detection to the `received` pulse: SAMPLING_RATE/2 + 9·SAMPLING_RATE ticks, plus 1 `clk`.
- Back-to-back frames are accepted: a start edge on the first IDLE tick after STOP is detected.
- If `baud` stops toggling, the FSM holds its state and produces no timeouts.

## Structure
- Shared package `uart_pkg`: the state encoding localparams (IDLE, START, DATA, STOP, BREAK), the frame data width (8) and the default SAMPLING_RATE. The transmit side uses the same package.
- One sub-module, `sync_edge`: a 2-flop synchronizer followed by a rising-edge detector, with a reset-value parameter. It is instantiated for `baud`. `bit_in` uses a synchronizer only.

## Test plan
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1), 16 ticks/bit, `clk` = 4× `baud` → one `received` pulse, `data_received==0xA5`, `framing_error` stays 0.
- Glitch: `bit_in` low for 3 ticks, then high → `receiving` rises, then falls by tick 8; no `received` pulse; `data_received` unchanged.
- Stop bit held low after 0x3C → one `framing_error` pulse, `data_received` keeps its old value. Line low for 40 more ticks → no new `receiving`. Line released and 0x3C sent again → received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap → two `received` pulses, with values 0x00 then 0xFF in order.
- `reset` asserted mid-DATA at bit 4, then a full 0x81 frame → no pulse for the aborted frame; 0x81 received.
- SAMPLING_RATE=4, frame 0x5A, with ±1 `clk` jitter on `baud` edges → `data_received==0x5A`.
